// File: rtl/mem_burst_responder.sv
// mem_burst_responder: single-port RAM serving one write and one read
// burst client with round-robin arbitration, all on mem_clk.
//
// Ports:
//   mem_clk, rst_n        clock, synchronous active-low reset
//   wr_burst_req/len/addr write request, beat count, start word address
//   wr_burst_data_req     pull strobe, one beat per high cycle
//   wr_burst_data         beat data, valid the cycle after each pull
//   wr_burst_finish       one-cycle write completion pulse
//   rd_burst_req/len/addr read request, beat count, start word address
//   rd_burst_data_valid   read beat strobe
//   rd_burst_data         read beat data
//   rd_burst_finish       one-cycle read completion pulse
module mem_burst_responder #(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 12
) (
    input  logic                     mem_clk,
    input  logic                     rst_n,
    input  logic                     wr_burst_req,
    input  logic [9:0]               wr_burst_len,
    input  logic [23:0]              wr_burst_addr,
    output logic                     wr_burst_data_req,
    input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
    output logic                     wr_burst_finish,
    input  logic                     rd_burst_req,
    input  logic [9:0]               rd_burst_len,
    input  logic [23:0]              rd_burst_addr,
    output logic                     rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0] rd_burst_data,
    output logic                     rd_burst_finish
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        CAP,
        DONE,
        GAP
    } state_t;

    state_t                 state;
    logic                   last_grant_rd;
    logic [9:0]             len_q;
    logic [9:0]             cnt;
    logic [ADDR_BITS-1:0]   base;
    logic [ADDR_BITS-1:0]   wptr;
    logic [ADDR_BITS-1:0]   raddr;
    logic                   we_q;
    logic                   grant_wr;
    logic                   grant_rd;

    logic [MEM_DATA_BITS-1:0] ram [2**ADDR_BITS];

    // Upper address bits are deliberately ignored (addresses wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{wr_burst_addr[23:ADDR_BITS],
                                rd_burst_addr[23:ADDR_BITS]};

    assign raddr = base + ADDR_BITS'(cnt);

    // With both requests up, the client not served last wins.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (wr_burst_req && (!rd_burst_req || last_grant_rd)) begin
            grant_wr = 1'b1;
        end else if (rd_burst_req) begin
            grant_rd = 1'b1;
        end
    end

    // Write data lags the pull strobe by one cycle, so the RAM write
    // is driven by a delayed copy of it. Not reset-gated: a beat that
    // was already pulled before reset still lands in the RAM.
    always_ff @(posedge mem_clk) begin
        if (we_q) begin
            ram[wptr] <= wr_burst_data;
        end
    end

    always_ff @(posedge mem_clk) begin
        if (!rst_n) begin
            state               <= IDLE;
            last_grant_rd       <= 1'b1;
            len_q               <= '0;
            cnt                 <= '0;
            base                <= '0;
            wptr                <= '0;
            we_q                <= 1'b0;
            wr_burst_data_req   <= 1'b0;
            wr_burst_finish     <= 1'b0;
            rd_burst_data_valid <= 1'b0;
            rd_burst_data       <= '0;
            rd_burst_finish     <= 1'b0;
        end else begin
            we_q <= wr_burst_data_req;
            if (we_q) begin
                wptr <= wptr + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (grant_wr) begin
                        len_q             <= wr_burst_len;
                        cnt               <= '0;
                        wptr              <= wr_burst_addr[ADDR_BITS-1:0];
                        last_grant_rd     <= 1'b0;
                        wr_burst_data_req <= (wr_burst_len != 10'd0);
                        state             <= (wr_burst_len != 10'd0) ? WR : CAP;
                    end else if (grant_rd) begin
                        len_q         <= rd_burst_len;
                        cnt           <= '0;
                        base          <= rd_burst_addr[ADDR_BITS-1:0];
                        last_grant_rd <= 1'b1;
                        state         <= RD;
                    end
                end
                WR: begin
                    cnt <= cnt + 10'd1;
                    if (cnt == len_q - 10'd1) begin
                        wr_burst_data_req <= 1'b0;
                        state             <= CAP;
                    end
                end
                // Last pulled beat is written this cycle.
                CAP: begin
                    wr_burst_finish <= 1'b1;
                    state           <= DONE;
                end
                // One extra cycle after the last issue to flush the
                // final beat before raising finish.
                RD: begin
                    if (cnt == len_q) begin
                        rd_burst_data_valid <= 1'b0;
                        rd_burst_finish     <= 1'b1;
                        state               <= DONE;
                    end else begin
                        rd_burst_data_valid <= 1'b1;
                        rd_burst_data       <= ram[raddr];
                        cnt                 <= cnt + 10'd1;
                    end
                end
                DONE: begin
                    wr_burst_finish <= 1'b0;
                    rd_burst_finish <= 1'b0;
                    state           <= GAP;
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
